// File: rtl/adc_cmd_responder.sv
// adc_cmd_responder: slave end of the cmd register bus for the ADC DSP
// control space. Each accepted sel strobe is answered by a one-cycle ack
// ACK_DELAY cycles later. Holds channel select, enable, sticky flow/collision
// status, a saturating sample counter and a scratch register.
module adc_cmd_responder #(
  parameter logic [31:0] ACTIVE_CHANNEL = 32'd1,
  parameter int unsigned ACK_DELAY      = 2,
  parameter logic [31:0] BAD_RDATA      = 32'hDEAD_BEEF,
  parameter int unsigned ADDR_W         = 8
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              cmd_sel,
  input  logic              cmd_rd_wr_n,
  input  logic [ADDR_W-1:0] cmd_byte_addr,
  input  logic [31:0]       cmd_wdata,
  output logic              cmd_ack,
  output logic [31:0]       cmd_rdata,
  input  logic              i_valid,
  input  logic              i_flow_problem,
  output logic [31:0]       o_channel,
  output logic              o_enable,
  output logic              o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] A_CHANNEL = ADDR_W'(8'h00);
  localparam logic [ADDR_W-1:0] A_CTRL    = ADDR_W'(8'h04);
  localparam logic [ADDR_W-1:0] A_STATUS  = ADDR_W'(8'h08);
  localparam logic [ADDR_W-1:0] A_COUNT   = ADDR_W'(8'h0C);
  localparam logic [ADDR_W-1:0] A_SCRATCH = ADDR_W'(8'h10);

  // With a delay of one the transaction goes straight from accept to ACK,
  // so the write/read must use the live bus values rather than the latch.
  localparam bit         DIRECT_ACK = (ACK_DELAY == 1);
  localparam logic [3:0] DLY_LOAD   = 4'(ACK_DELAY - 1);

  state_t              state_r;
  logic [3:0]          dly_r;
  logic                req_rd_r;
  logic [ADDR_W-1:0]   req_addr_r;
  logic [31:0]         req_wdata_r;
  logic [1:0]          status_r;
  logic [31:0]         count_r;
  logic [31:0]         scratch_r;

  logic                accept_s;
  logic                collide_s;
  logic                enter_ack_s;
  logic                txn_rd_s;
  logic [ADDR_W-1:0]   txn_addr_s;
  logic [31:0]         txn_wdata_s;
  logic                wr_s;
  logic                soft_clr_s;
  logic [1:0]          w1c_s;
  logic [31:0]         rd_val_s;

  // Transaction control: accept, collision detect and the edge that enters ACK.
  always_comb begin
    accept_s    = cmd_sel && ((state_r == ST_IDLE) || (state_r == ST_ACK));
    collide_s   = cmd_sel && (state_r == ST_WAIT);
    enter_ack_s = (accept_s && DIRECT_ACK) ||
                  ((state_r == ST_WAIT) && (dly_r <= 4'd1));
    if (DIRECT_ACK) begin
      txn_rd_s    = cmd_rd_wr_n;
      txn_addr_s  = cmd_byte_addr;
      txn_wdata_s = cmd_wdata;
    end else begin
      txn_rd_s    = req_rd_r;
      txn_addr_s  = req_addr_r;
      txn_wdata_s = req_wdata_r;
    end
    wr_s = enter_ack_s && !txn_rd_s;
  end

  // Write side effects: soft clear pulse and status W1C mask.
  always_comb begin
    soft_clr_s = 1'b0;
    w1c_s      = 2'b00;
    if (wr_s && (txn_addr_s == A_CTRL)) begin
      soft_clr_s = txn_wdata_s[1];
    end else begin
      soft_clr_s = 1'b0;
    end
    if (wr_s && (txn_addr_s == A_STATUS)) begin
      w1c_s = txn_wdata_s[1:0];
    end else begin
      w1c_s = 2'b00;
    end
  end

  // Read mux: register value as seen on the edge entering ACK.
  always_comb begin
    rd_val_s = BAD_RDATA;
    case (txn_addr_s)
      A_CHANNEL: rd_val_s = o_channel;
      A_CTRL:    rd_val_s = {31'd0, o_enable};
      A_STATUS:  rd_val_s = {30'd0, status_r};
      A_COUNT:   rd_val_s = count_r;
      A_SCRATCH: rd_val_s = scratch_r;
      default:   rd_val_s = BAD_RDATA;
    endcase
  end

  // Request FSM with registered ack, rdata and busy.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r     <= ST_IDLE;
      dly_r       <= 4'd0;
      req_rd_r    <= 1'b0;
      req_addr_r  <= '0;
      req_wdata_r <= 32'd0;
      cmd_ack     <= 1'b0;
      cmd_rdata   <= 32'd0;
      o_busy      <= 1'b0;
    end else begin
      cmd_ack   <= enter_ack_s;
      cmd_rdata <= (enter_ack_s && txn_rd_s) ? rd_val_s : 32'd0;
      case (state_r)
        ST_IDLE, ST_ACK: begin
          if (accept_s) begin
            req_rd_r    <= cmd_rd_wr_n;
            req_addr_r  <= cmd_byte_addr;
            req_wdata_r <= cmd_wdata;
            dly_r       <= DLY_LOAD;
            state_r     <= DIRECT_ACK ? ST_ACK : ST_WAIT;
            o_busy      <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            o_busy  <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (dly_r <= 4'd1) begin
            state_r <= ST_ACK;
          end else begin
            dly_r <= dly_r - 4'd1;
          end
          o_busy <= 1'b1;
        end
        default: begin
          state_r <= ST_IDLE;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

  // RW control registers: channel, enable, scratch.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_channel <= ACTIVE_CHANNEL;
      o_enable  <= 1'b1;
      scratch_r <= 32'd0;
    end else if (wr_s) begin
      case (txn_addr_s)
        A_CHANNEL: o_channel <= txn_wdata_s;
        A_CTRL:    o_enable  <= txn_wdata_s[0];
        A_SCRATCH: scratch_r <= txn_wdata_s;
        default:   scratch_r <= scratch_r;
      endcase
    end
  end

  // Sticky status: a new event on the same edge as W1C keeps the bit set.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      status_r <= 2'b00;
    end else begin
      status_r <= (status_r & ~w1c_s) | {collide_s, i_flow_problem};
    end
  end

  // Saturating sample counter; soft clear beats a same-cycle sample.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      count_r <= 32'd0;
    end else if (soft_clr_s) begin
      count_r <= 32'd0;
    end else if (i_valid && o_enable && (count_r != 32'hFFFF_FFFF)) begin
      count_r <= count_r + 32'd1;
    end
  end

endmodule
